// File: rtl/pio_in_debounce_pkg.sv
// Shared register map and helpers for the debounced input PIO.
package pio_in_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA     = 3'd0,
    ADDR_RAW      = 3'd1,
    ADDR_IRQ_MASK = 3'd2,
    ADDR_EDGE_CAP = 3'd3,
    ADDR_RISE_EN  = 3'd4,
    ADDR_FALL_EN  = 3'd5
  } pio_addr_e;

  // Width of a counter that must hold 0..cycles; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pio_in_debounce_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
interface pio_in_debounce_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_debounce_ch.sv
// One input channel: synchroniser chain, stability counter, debounced value
// and its one-cycle delayed copy for edge detection.
module pio_debounce_ch
  import pio_in_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic raw,
  output logic deb,
  output logic deb_q
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the synchroniser flops.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
  end

  assign raw = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // Filter disabled: debounced value follows the synchroniser output.
      always_ff @(posedge clk) begin
        if (reset) deb <= 1'b0;
        else       deb <= raw;
      end
    end else begin : g_filter
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt;

      // Count consecutive cycles raw differs from deb; accept on the last one.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt <= '0;
          deb <= 1'b0;
        end else if (raw == deb) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          deb <= raw;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

  // Delay deb one cycle so the top level can see transitions.
  always_ff @(posedge clk) begin
    if (reset) deb_q <= 1'b0;
    else       deb_q <= deb;
  end

endmodule

// File: rtl/pio_in_debounce.sv
// Parametrised Avalon-MM input PIO with per-bit debounce, edge enables,
// write-1-to-clear edge capture and a masked level interrupt.
module pio_in_debounce
  import pio_in_pkg::*;
#(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 1000,
  parameter logic [WIDTH-1:0] RISE_RESET      = '1,
  parameter logic [WIDTH-1:0] FALL_RESET      = '0
) (
  input  logic               clk,
  input  logic               reset,
  pio_in_debounce_if.slave   bus,
  input  logic [WIDTH-1:0]   in_port,
  output logic               irq
);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdata;
  logic             wr;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      pio_debounce_ch #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
        .clk   (clk),
        .reset (reset),
        .in_bit(in_port[i]),
        .raw   (raw[i]),
        .deb   (deb[i]),
        .deb_q (deb_q[i])
      );
    end
  endgenerate

  assign wr    = bus.chipselect & ~bus.write_n;
  assign wdata = bus.writedata[WIDTH-1:0];

  // Edge qualification and write-1-to-clear mask for the capture register.
  always_comb begin
    edge_hit = (deb & ~deb_q & rise_en) | (~deb & deb_q & fall_en);
    clr      = '0;
    if (wr && (bus.address == ADDR_EDGE_CAP)) clr = wdata;
  end

  // Control registers and edge capture; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      rise_en      <= RISE_RESET;
      fall_en      <= FALL_RESET;
    end else begin
      edge_capture <= (edge_capture & ~clr) | edge_hit;
      if (wr) begin
        case (bus.address)
          ADDR_IRQ_MASK: irq_mask <= wdata;
          ADDR_RISE_EN:  rise_en  <= wdata;
          ADDR_FALL_EN:  fall_en  <= wdata;
          default: ;
        endcase
      end
    end
  end

  // Registered read mux, refreshed every cycle from the current address.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
    end else begin
      case (bus.address)
        ADDR_DATA:     bus.readdata <= 32'(deb);
        ADDR_RAW:      bus.readdata <= 32'(raw);
        ADDR_IRQ_MASK: bus.readdata <= 32'(irq_mask);
        ADDR_EDGE_CAP: bus.readdata <= 32'(edge_capture);
        ADDR_RISE_EN:  bus.readdata <= 32'(rise_en);
        ADDR_FALL_EN:  bus.readdata <= 32'(fall_en);
        default:       bus.readdata <= '0;
      endcase
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_in_debounce.sv
// Bench for pio_in_debounce: directed scenarios with literal expectations
// plus randomized stimulus, all checked against a window-based model.
module tb_pio_in_debounce;

  localparam int W = 4;
  localparam int S = 2;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_port = '0;
  logic         irq;

  pio_in_debounce_if bus ();

  pio_in_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .RISE_RESET     (4'hF),
    .FALL_RESET     (4'h0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .in_port(in_port),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // Behavioural model. The debounced value switches when the last D
  // synchronised samples since reset all agree and differ from it.
  logic [W-1:0]  m_pipe [S];
  logic [W-1:0]  m_hist [$];
  logic [W-1:0]  m_deb, m_debq, m_ec, m_mask, m_rise, m_fall;
  logic [31:0]   m_rd;
  logic          m_irq;
  bit            m_valid = 0;

  always @(posedge clk) begin : model
    logic [W-1:0] raw_pre, edge_v, clr, deb_n;
    logic         wr_v;
    bit           same;
    if (reset) begin
      for (int i = 0; i < S; i++) m_pipe[i] = '0;
      m_hist.delete();
      m_deb = '0; m_debq = '0; m_ec = '0; m_mask = '0;
      m_rise = 4'hF; m_fall = 4'h0; m_rd = '0;
      m_valid = 1;
    end else begin
      raw_pre = m_pipe[S-1];
      case (bus.address)
        3'd0: m_rd = {28'd0, m_deb};
        3'd1: m_rd = {28'd0, raw_pre};
        3'd2: m_rd = {28'd0, m_mask};
        3'd3: m_rd = {28'd0, m_ec};
        3'd4: m_rd = {28'd0, m_rise};
        3'd5: m_rd = {28'd0, m_fall};
        default: m_rd = '0;
      endcase
      wr_v   = bus.chipselect && !bus.write_n;
      edge_v = (m_deb & ~m_debq & m_rise) | (~m_deb & m_debq & m_fall);
      clr    = (wr_v && bus.address == 3'd3) ? bus.writedata[W-1:0] : '0;
      m_ec   = (m_ec & ~clr) | edge_v;
      if (wr_v && bus.address == 3'd2) m_mask = bus.writedata[W-1:0];
      if (wr_v && bus.address == 3'd4) m_rise = bus.writedata[W-1:0];
      if (wr_v && bus.address == 3'd5) m_fall = bus.writedata[W-1:0];
      m_hist.push_back(raw_pre);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      deb_n = m_deb;
      if (m_hist.size() == D) begin
        for (int b = 0; b < W; b++) begin
          same = 1;
          foreach (m_hist[k]) if (m_hist[k][b] != raw_pre[b]) same = 0;
          if (same && raw_pre[b] != m_deb[b]) deb_n[b] = raw_pre[b];
        end
      end
      m_debq = m_deb;
      m_deb  = deb_n;
      for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = in_port;
    end
    m_irq = |(m_ec & m_mask);
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("readdata", bus.readdata, m_rd);
      check("irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = $urandom();
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] v);
    bus.address = a;
    @(negedge clk);
    v = bus.readdata;
  endtask

  int hold [W];

  initial begin
    logic [31:0] v;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    bus_rd(3'd0, v); check("reset_data", v, 32'h0);
    bus_rd(3'd4, v); check("reset_rise_en", v, 32'hF);
    bus_rd(3'd5, v); check("reset_fall_en", v, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);

    // Bit0 rising: deb after 10 edges, readdata after 11, capture after 11
    bus.address = 3'd0;
    in_port[0] = 1'b1;
    repeat (9) @(negedge clk);
    check("model_deb0_t9", {28'd0, m_deb}, 32'h0);
    @(negedge clk);
    check("model_deb0_t10", {28'd0, m_deb}, 32'h1);
    check("data_t10", bus.readdata, 32'h0);
    @(negedge clk);
    check("data_t11", bus.readdata, 32'h1);
    check("model_ec_t11", {28'd0, m_ec}, 32'h1);
    bus_wr(3'd2, 32'h1);
    check("irq_unmasked", {31'd0, irq}, 32'h1);
    bus_rd(3'd3, v); check("ec_bit0", v, 32'h1);
    bus_wr(3'd3, 32'h1);
    check("irq_cleared", {31'd0, irq}, 32'h0);
    bus_rd(3'd3, v); check("ec_cleared", v, 32'h0);

    // Bit1 glitch of 5 cycles: visible on RAW, never on DATA
    in_port[1] = 1'b1;
    repeat (3) @(negedge clk);
    bus_rd(3'd1, v); check("raw_glitch", v, 32'h3);
    @(negedge clk);
    in_port[1] = 1'b0;
    repeat (20) @(negedge clk);
    bus_rd(3'd0, v); check("data_after_glitch", v, 32'h1);
    bus_rd(3'd3, v); check("ec_after_glitch", v, 32'h0);

    // Bit2: falling edge only
    bus_wr(3'd4, 32'hB);
    bus_wr(3'd5, 32'h4);
    in_port[2] = 1'b1;
    repeat (20) @(negedge clk);
    bus_rd(3'd3, v); check("ec_rise_disabled", v, 32'h0);
    bus_rd(3'd0, v); check("data_bit2_high", v, 32'h5);
    in_port[2] = 1'b0;
    repeat (20) @(negedge clk);
    bus_rd(3'd3, v); check("ec_fall", v, 32'h4);
    bus_wr(3'd3, 32'h4);
    bus_rd(3'd3, v); check("ec_fall_cleared", v, 32'h0);
    bus_wr(3'd4, 32'hF);

    // Bit1 edge captured on the same edge as a clear of bit1: set wins
    in_port[1] = 1'b1;
    repeat (10) @(negedge clk);
    bus_wr(3'd3, 32'h2);
    bus_rd(3'd3, v); check("set_wins", v, 32'h2);
    bus_wr(3'd3, 32'h2);

    // Reset while bit3 counter is at 5; held-high inputs recapture at full latency
    in_port[3] = 1'b1;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.address = 3'd0;
    @(negedge clk);
    check("data_after_reset", bus.readdata, 32'h0);
    bus.address = 3'd3;
    repeat (10) @(negedge clk);
    check("ec_before_latency", bus.readdata, 32'h0);
    @(negedge clk);
    check("ec_at_latency", bus.readdata, 32'hB);

    // Randomized traffic
    foreach (hold[b]) hold[b] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int b = 0; b < W; b++) begin
        if (hold[b] == 0) begin
          in_port[b] = 1'($urandom_range(0, 1));
          hold[b] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 30);
        end else begin
          hold[b]--;
        end
      end
      reset = ($urandom_range(0, 499) == 0);
      bus.address = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) begin
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
      end else begin
        bus.chipselect = 1'($urandom_range(0, 1)); bus.write_n = 1'b1;
      end
      bus.writedata = $urandom();
      @(negedge clk);
    end
    reset = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
